// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit: tracks in-flight destinations across
// FWD_DEPTH post-issue slots, forwards from the youngest match, stalls on early loads.
module fwd_hazard_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned LOAD_STAGE = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        iss_valid,
  output logic                        iss_ready,
  input  logic [REG_AW-1:0]           iss_src1,
  input  logic [REG_AW-1:0]           iss_src2,
  input  logic                        iss_use_src2,
  input  logic                        iss_wb_en,
  input  logic [REG_AW-1:0]           iss_dest,
  input  logic                        iss_is_load,
  input  logic                        flush,
  input  logic [DATA_W-1:0]           rf_data1,
  input  logic [DATA_W-1:0]           rf_data2,
  input  logic [DATA_W*FWD_DEPTH-1:0] stage_result,
  output logic [DATA_W-1:0]           src_out1,
  output logic [DATA_W-1:0]           src_out2,
  output logic                        fwd_hit1,
  output logic                        fwd_hit2,
  output logic [CNT_W-1:0]            stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic [REG_AW-1:0] dest;
    logic              is_load;
  } slot_t;

  slot_t            slot_q [FWD_DEPTH];
  slot_t            slot_d [FWD_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic blk1, blk2, found1, found2;

  function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.wb_en && (s.dest == r) && (r != '0);
  endfunction

  // Ascending scan with a found flag: the first (youngest) match shadows all older ones.
  always_comb begin
    src_out1 = rf_data1;
    src_out2 = rf_data2;
    fwd_hit1 = 1'b0;
    fwd_hit2 = 1'b0;
    blk1     = 1'b0;
    blk2     = 1'b0;
    found1   = 1'b0;
    found2   = 1'b0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      if (!found1 && slot_match(slot_q[k], iss_src1)) begin
        found1 = 1'b1;
        if (slot_q[k].is_load && (k < LOAD_STAGE)) begin
          blk1 = 1'b1;
        end else begin
          fwd_hit1 = 1'b1;
          src_out1 = stage_result[k*DATA_W +: DATA_W];
        end
      end
      if (iss_use_src2 && !found2 && slot_match(slot_q[k], iss_src2)) begin
        found2 = 1'b1;
        if (slot_q[k].is_load && (k < LOAD_STAGE)) begin
          blk2 = 1'b1;
        end else begin
          fwd_hit2 = 1'b1;
          src_out2 = stage_result[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign iss_ready = !(iss_valid && (blk1 || blk2));
  assign stall_cnt = cnt_q;

  always_comb begin
    slot_d = '{default: '0};
    if (iss_valid && iss_ready && !flush) begin
      slot_d[0] = '{valid: 1'b1, wb_en: iss_wb_en, dest: iss_dest, is_load: iss_is_load};
    end
    for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (iss_valid && !iss_ready && !flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '{default: '0};
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default instance for forwarding/stall/flush/reset,
// and a deep-load, 4-bit-counter instance for stall-counter saturation.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Default instance: DATA_W=32, FWD_DEPTH=2, LOAD_STAGE=1, CNT_W=16
  logic        iss_valid, iss_ready, iss_use_src2, iss_wb_en, iss_is_load, flush;
  logic [4:0]  iss_src1, iss_src2, iss_dest;
  logic [31:0] rf_data1, rf_data2, src_out1, src_out2;
  logic [63:0] stage_result;
  logic        fwd_hit1, fwd_hit2;
  logic [15:0] stall_cnt;

  fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .FWD_DEPTH(2), .LOAD_STAGE(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_use_src2(iss_use_src2),
    .iss_wb_en(iss_wb_en), .iss_dest(iss_dest), .iss_is_load(iss_is_load), .flush(flush),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .stage_result(stage_result),
    .src_out1(src_out1), .src_out2(src_out2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .stall_cnt(stall_cnt)
  );

  // Saturation instance: FWD_DEPTH=6, LOAD_STAGE=6, CNT_W=4
  logic         s_valid, s_ready, s_use2, s_wb, s_load, s_flush;
  logic [4:0]   s_src1, s_src2, s_dest;
  logic [31:0]  s_rf1, s_rf2, s_out1, s_out2;
  logic [191:0] s_stage;
  logic         s_hit1, s_hit2;
  logic [3:0]   s_cnt;

  fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .FWD_DEPTH(6), .LOAD_STAGE(6), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .iss_valid(s_valid), .iss_ready(s_ready),
    .iss_src1(s_src1), .iss_src2(s_src2), .iss_use_src2(s_use2),
    .iss_wb_en(s_wb), .iss_dest(s_dest), .iss_is_load(s_load), .flush(s_flush),
    .rf_data1(s_rf1), .rf_data2(s_rf2), .stage_result(s_stage),
    .src_out1(s_out1), .src_out2(s_out2), .fwd_hit1(s_hit1), .fwd_hit2(s_hit2),
    .stall_cnt(s_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic use2,
                       input logic wb, input logic [4:0] d, input logic ld);
    iss_valid = 1'b1; iss_src1 = s1; iss_src2 = s2; iss_use_src2 = use2;
    iss_wb_en = wb; iss_dest = d; iss_is_load = ld;
  endtask

  initial begin
    int n;
    int exp_cnt;
    iss_valid = 0; iss_src1 = 0; iss_src2 = 0; iss_use_src2 = 0; iss_wb_en = 0;
    iss_dest = 0; iss_is_load = 0; flush = 0;
    rf_data1 = 32'h1111_1111; rf_data2 = 32'h2222_2222; stage_result = '0;
    s_valid = 0; s_src1 = 0; s_src2 = 0; s_use2 = 0; s_wb = 0; s_dest = 0; s_load = 0;
    s_flush = 0; s_rf1 = 32'h5555_5555; s_rf2 = 32'h6666_6666; s_stage = '1;

    // Reset state
    step();
    rst = 1'b0;
    issue(5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    check("rst_ready", iss_ready, 1);
    check("rst_hit1", fwd_hit1, 0);
    check("rst_hit2", fwd_hit2, 0);
    check("rst_src1", src_out1, 32'h1111_1111);
    check("rst_src2", src_out2, 32'h2222_2222);
    check("rst_cnt", stall_cnt, 0);

    // ALU chain: add r3, then sub using r3
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
    step();
    issue(5'd3, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0);
    stage_result = {32'hDEAD_BEEF, 32'h0000_0011};
    #1;
    check("alu_src1", src_out1, 32'h11);
    check("alu_hit1", fwd_hit1, 1);
    check("alu_ready", iss_ready, 1);
    check("alu_src2", src_out2, 32'h2222_2222);
    check("alu_hit2", fwd_hit2, 0);
    step();

    // Priority: r5 in slot 0 and slot 1, youngest wins
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    step();
    step();
    issue(5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    stage_result = {32'hBBBB_0000, 32'hAAAA_0000};
    #1;
    check("pri_src1", src_out1, 32'hAAAA_0000);
    check("pri_src2", src_out2, 32'hAAAA_0000);
    check("pri_hit1", fwd_hit1, 1);
    check("pri_hit2", fwd_hit2, 1);
    step();

    // Load-use with LOAD_STAGE=1: one stall cycle then forward from slot 1
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
    #1;
    check("lw_ready", iss_ready, 1);
    step();
    issue(5'd7, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
    stage_result = {32'h1234_5678, 32'h9999_9999};
    #1;
    check("lu_stall", iss_ready, 0);
    step();
    check("lu_cnt", stall_cnt, 1);
    check("lu_ready", iss_ready, 1);
    check("lu_src1", src_out1, 32'h1234_5678);
    check("lu_hit1", fwd_hit1, 1);
    step();
    iss_valid = 0;
    step();
    step();

    // r0 never forwarded; immediate src2 ignores in-flight r4
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    step();
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    step();
    issue(5'd0, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0);
    stage_result = {32'h4444_4444, 32'h0000_0000};
    #1;
    check("r0_src1", src_out1, 32'h1111_1111);
    check("r0_hit1", fwd_hit1, 0);
    check("imm_src2", src_out2, 32'h2222_2222);
    check("imm_hit2", fwd_hit2, 0);
    check("imm_ready", iss_ready, 1);
    iss_use_src2 = 1'b1;
    #1;
    check("r4_src2", src_out2, 32'h4444_4444);
    check("r4_hit2", fwd_hit2, 1);
    step();

    // Flush during load-use stall
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
    step();
    issue(5'd7, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_ready", iss_ready, 0);
    step();
    flush = 1'b0;
    check("fl_cnt", stall_cnt, 1);
    issue(5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    check("fl_bubble_hit", fwd_hit1, 0);
    check("fl_bubble_src", src_out1, 32'h1111_1111);
    iss_valid = 0;
    step();
    step();

    // Reset mid-stall
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
    step();
    issue(5'd7, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
    #1;
    check("rs_stall", iss_ready, 0);
    check("rs_cnt_pre", stall_cnt, 1);
    rst = 1'b1;
    step();
    check("rs_ready", iss_ready, 1);
    check("rs_cnt", stall_cnt, 0);
    check("rs_hit1", fwd_hit1, 0);
    rst = 1'b0;
    iss_valid = 0;
    step();

    // Saturation: LOAD_STAGE=FWD_DEPTH=6, 6 stall cycles per load, 4-bit counter
    for (int r = 0; r < 4; r++) begin
      s_valid = 1; s_src1 = 0; s_use2 = 0; s_wb = 1; s_dest = 5'd7; s_load = 1;
      step();
      s_src1 = 5'd7; s_wb = 0; s_load = 0; s_dest = 0;
      #1;
      n = 0;
      while (!s_ready && n < 20) begin
        step();
        n++;
      end
      check("sat_stall_len", n, 6);
      exp_cnt = (6 * (r + 1) > 15) ? 15 : 6 * (r + 1);
      check("sat_cnt", s_cnt, exp_cnt);
      if (r == 0) begin
        check("sat_rf_src1", s_out1, 32'h5555_5555);
        check("sat_rf_hit1", s_hit1, 0);
      end
      step();
      s_valid = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
